seg7_scan_controller: RTL and testbench
=======================================

// Module: seg7_scan_controller
// PURPOSE
//  Parametrised multiplexed N-digit seven-segment driver.
//  - Latches per-digit values, decimal points and blank masks on a load strobe.
//  - Time-multiplexes the digits through a shared segment bus, with anti-ghost dead time.
//  - Optional hex glyphs and a whole-display blink.
//  - Sits between the result/status logic of system_controller and the board pins (seg, decimalPoint, an).
// PARAMETERS
//  NUM_DIGITS   4       digits scanned, legal 1..8; digit 0 = rightmost, an[0]
//  REFRESH_DIV  100000  clk cycles each digit is driven (ON time), >= 2
//  DEAD_CYCLES  8       all-off cycles between digits, 0 = no dead state
//  HEX_MODE     0       1: values 10-15 show A,b,C,d,E,F; 0: values 10-15 blank
//  BLINK_BITS   24      blink counter width; blink phase = counter MSB
//  SEG_ACT_LOW  1       1: seg/an pins active-low; decimalPoint is always active-high
// PORTS
//  clk           in   1             system clock
//  rst_n         in   1             async active-low reset
//  clear         in   1             sync: invalidate contents, blank display
//  load          in   1             sync strobe: capture the three *_in buses
//  digits_in     in   4*NUM_DIGITS  nibble k = value of digit k
//  dp_in         in   NUM_DIGITS    decimal point per digit, 1 = lit
//  blank_in      in   NUM_DIGITS    1 = force digit k dark
//  blink_en      in   1             1 = blank segments during blink phase
//  seg           out  7             segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  decimalPoint  out  1             lit DP of the active digit
//  an            out  NUM_DIGITS    one-hot anode enable, polarity per SEG_ACT_LOW
//  valid         out  1             1 = contents loaded since reset/clear
// BEHAVIOUR
//  - Reset (async): all outputs are registered and are inactive during reset.
//    - seg all off, an all off, decimalPoint = 0, valid = 0.
//    - State = BLANK, digit index = 0, scan and blink counters = 0.
//  - Load/clear
//    - load at edge N: shadow registers are updated at N; valid = 1 at N.
//    - clear = 1 forces valid = 0 and state = BLANK. clear wins over a simultaneous load.
//  - FSM states: BLANK, ON, DEAD.
//    - BLANK: outputs off. Moves to ON at digit 0 with scan_cnt = 0 when valid = 1.
//    - ON: an drives the current digit. scan_cnt counts 0..REFRESH_DIV-1.
//      - At terminal count, go to DEAD, or to ON with the next digit if DEAD_CYCLES = 0.
//    - DEAD: an and seg off for DEAD_CYCLES cycles, then ON with the next digit.
//    - Digit index wraps NUM_DIGITS-1 -> 0.
//    - From any state, valid = 0 -> BLANK on the next edge, and the index resets to 0.
//  - Scan period per digit = REFRESH_DIV + DEAD_CYCLES cycles.
//  - Output pipeline
//    - Glyph from the current digit's shadow value is encoded combinationally, then registered once.
//    - seg, an and decimalPoint change together, 1 cycle after the state/index change.
//    - A load affecting the active digit is visible on the pins 1 cycle after its capture edge.
//  - Glyph rules
//    - 0-9 use the standard patterns, e.g. 0 = 7'b100_0000 active-low, 8 = 7'b000_0000.
//    - 10-15 follow HEX_MODE.
//  - Per-digit masking
//    - blank_in[k] = 1: seg off and decimalPoint = 0 for digit k; the anode still scans.
//  - Blink
//    - blink counter free-runs while valid = 1 and wraps at 2^BLINK_BITS. Reset/clear zero it.
//    - blink_en = 1 and MSB = 1: seg and decimalPoint are off; anodes keep scanning.
//  - Parameter widths
//    - Counters are sized with $clog2 of their terminal value, minimum 1 bit.
//    - Out-of-range parameters stop elaboration with $fatal.
// STRUCTURE
//  - seg7_pkg holds:
//    - typedef enum {BLANK, ON, DEAD} scan_state_t.
//    - The 7-bit glyph constants and SEG_OFF.
//    - function seg7_encode(value, hex_mode), returning the active-low pattern.
//  - Polarity is applied only at the output register.
//  - Sub-module seg7_scan_timer: scan/dead counters, FSM and digit index, with outputs state and idx.
//  - Top level holds the shadow registers, the blink counter and the output registers.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_BITS=3, HEX_MODE=0)
//  - Reset released, no load:
//    -> seg = 7'h7F, an = 4'hF, decimalPoint = 0, valid = 0 for 50 cycles.
//  - load digits_in = 16'h4321, dp_in = 4'b0001, blank_in = 0:
//    -> an cycles 1110,1101,1011,0111, each for 4 cycles with 1 cycle of 1111 between.
//    -> seg = 1,2,3,4 glyphs; decimalPoint = 1 only while an = 1110.
//  - Digit value 4'hA with HEX_MODE=0 -> seg = 7'h7F. Rerun with HEX_MODE=1 -> seg = 7'b000_1000 ('A').
//  - clear and load asserted in the same cycle mid-scan:
//    -> valid = 0, state = BLANK, an = 1111 one cycle later.
//    -> The next load restarts scanning at an = 1110.
//  - blink_en = 1:
//    -> seg is off for 4 of every 8 cycles; an scanning is unaffected.
//    -> blank_in = 4'b0100 -> an = 1011 shows seg = 7'h7F.
//  - Assert rst_n = 0 mid-ON, asynchronously between edges:
//    -> Outputs are off immediately, with no waiting for a clock edge.
//    -> valid = 0 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment driver.
// All patterns are active-low {g,f,e,d,c,b,a}; pin polarity is applied at the output register.
package seg7_pkg;

    typedef enum logic [1:0] {BLANK, ON, DEAD} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    function automatic logic [6:0] seg7_encode(input logic [3:0] value, input logic hex_mode);
        logic [6:0] pattern;
        case (value)
            4'h0: pattern = GLYPH_0;
            4'h1: pattern = GLYPH_1;
            4'h2: pattern = GLYPH_2;
            4'h3: pattern = GLYPH_3;
            4'h4: pattern = GLYPH_4;
            4'h5: pattern = GLYPH_5;
            4'h6: pattern = GLYPH_6;
            4'h7: pattern = GLYPH_7;
            4'h8: pattern = GLYPH_8;
            4'h9: pattern = GLYPH_9;
            4'hA: pattern = hex_mode ? GLYPH_A : SEG_OFF;
            4'hB: pattern = hex_mode ? GLYPH_B : SEG_OFF;
            4'hC: pattern = hex_mode ? GLYPH_C : SEG_OFF;
            4'hD: pattern = hex_mode ? GLYPH_D : SEG_OFF;
            4'hE: pattern = hex_mode ? GLYPH_E : SEG_OFF;
            default: pattern = hex_mode ? GLYPH_F : SEG_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan sequencer: ON/DEAD dwell counters, BLANK/ON/DEAD state machine and digit index.
// Any loss of valid (or a clear) returns the scan to BLANK at digit 0.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 8,
    parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    output scan_state_t       state,
    output logic [IDX_W-1:0]  idx
);

    localparam int SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DEAD_TC = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
    localparam int DEAD_W  = (DEAD_TC > 0) ? $clog2(DEAD_TC + 1) : 1;

    scan_state_t        state_nxt;
    logic [SCAN_W-1:0]  scan_cnt, scan_cnt_nxt;
    logic [DEAD_W-1:0]  dead_cnt, dead_cnt_nxt;
    logic [IDX_W-1:0]   idx_nxt, idx_inc;
    logic               scan_tc, dead_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BLANK;
            scan_cnt <= '0;
            dead_cnt <= '0;
            idx      <= '0;
        end else begin
            state    <= state_nxt;
            scan_cnt <= scan_cnt_nxt;
            dead_cnt <= dead_cnt_nxt;
            idx      <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        scan_cnt_nxt = scan_cnt;
        dead_cnt_nxt = dead_cnt;
        idx_nxt      = idx;
        if (clear || !valid) begin
            state_nxt    = BLANK;
            scan_cnt_nxt = '0;
            dead_cnt_nxt = '0;
            idx_nxt      = '0;
        end else begin
            case (state)
                BLANK: begin
                    state_nxt    = ON;
                    scan_cnt_nxt = '0;
                    idx_nxt      = '0;
                end
                ON: begin
                    if (scan_tc) begin
                        scan_cnt_nxt = '0;
                        // Without dead time the next digit follows back-to-back
                        if (DEAD_CYCLES == 0) begin
                            idx_nxt = idx_inc;
                        end else begin
                            state_nxt    = DEAD;
                            dead_cnt_nxt = '0;
                        end
                    end else begin
                        scan_cnt_nxt = scan_cnt + 1'b1;
                    end
                end
                DEAD: begin
                    if (dead_tc) begin
                        state_nxt    = ON;
                        dead_cnt_nxt = '0;
                        idx_nxt      = idx_inc;
                    end else begin
                        dead_cnt_nxt = dead_cnt + 1'b1;
                    end
                end
                default: state_nxt = BLANK;
            endcase
        end
    end

    always_comb begin
        scan_tc = (scan_cnt == SCAN_W'(REFRESH_DIV - 1));
        dead_tc = (dead_cnt == DEAD_W'(DEAD_TC));
        idx_inc = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed N-digit seven-segment driver: shadow registers, blink counter,
// glyph encode and a single output register stage that also applies pin polarity.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 8,
    parameter int HEX_MODE    = 0,
    parameter int BLINK_BITS  = 24,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    decimalPoint,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    valid
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_PIN_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = (SEG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $fatal(1, "seg7_scan_controller: NUM_DIGITS must be 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $fatal(1, "seg7_scan_controller: REFRESH_DIV must be >= 2");
    end
    if (DEAD_CYCLES < 0) begin : g_bad_dead
        $fatal(1, "seg7_scan_controller: DEAD_CYCLES must be >= 0");
    end
    if (HEX_MODE != 0 && HEX_MODE != 1) begin : g_bad_hex
        $fatal(1, "seg7_scan_controller: HEX_MODE must be 0 or 1");
    end
    if (BLINK_BITS < 1) begin : g_bad_blink
        $fatal(1, "seg7_scan_controller: BLINK_BITS must be >= 1");
    end
    if (SEG_ACT_LOW != 0 && SEG_ACT_LOW != 1) begin : g_bad_pol
        $fatal(1, "seg7_scan_controller: SEG_ACT_LOW must be 0 or 1");
    end

    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh, blank_sh;
    logic [BLINK_BITS-1:0]   blink_cnt;
    scan_state_t             state;
    logic [IDX_W-1:0]        idx;

    logic [3:0]              cur_val;
    logic                    lit;
    logic [6:0]              seg_p0;
    logic                    dp_p0;
    logic [NUM_DIGITS-1:0]   an_p0;

    seg7_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .valid (valid),
        .state (state),
        .idx   (idx)
    );

    // Shadow contents are only meaningful while valid, so they carry no reset
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            digits_sh <= digits_in;
            dp_sh     <= dp_in;
            blank_sh  <= blank_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            blink_cnt <= '0;
        end else if (clear) begin
            valid     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
            end
            if (valid) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage p0: combinational glyph selection for the active digit
    always_comb begin
        cur_val = digits_sh[{idx, 2'b00} +: 4];
        lit     = (state == ON) && !blank_sh[idx] && !(blink_en && blink_cnt[BLINK_BITS-1]);
        seg_p0  = lit ? seg7_encode(cur_val, HEX_MODE != 0) : SEG_OFF;
        dp_p0   = lit && dp_sh[idx];
        an_p0   = (state == ON) ? (NUM_DIGITS'(1) << idx) : '0;
    end

    // Stage p1: registered pins with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg          <= SEG_PIN_OFF;
            an           <= AN_PIN_OFF;
            decimalPoint <= 1'b0;
        end else begin
            seg          <= (SEG_ACT_LOW != 0) ? seg_p0 : ~seg_p0;
            an           <= (SEG_ACT_LOW != 0) ? ~an_p0 : an_p0;
            decimalPoint <= dp_p0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with a short scan (4 ON + 1 dead cycle per digit).
// A second instance with hex glyphs enabled shares every input with the first.
module tb_seg7_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        blink_en;
    logic [6:0]  seg, seg_h;
    logic        decimalPoint, dp_h;
    logic [3:0]  an, an_h;
    logic        valid, valid_h;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_load = 0;
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic [3:0]  blv;

    seg7_scan_controller #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .HEX_MODE(0), .BLINK_BITS(3), .SEG_ACT_LOW(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .blink_en(blink_en),
        .seg(seg), .decimalPoint(decimalPoint), .an(an), .valid(valid)
    );

    seg7_scan_controller #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .HEX_MODE(1), .BLINK_BITS(3), .SEG_ACT_LOW(1)
    ) u_hex (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .blink_en(blink_en),
        .seg(seg_h), .decimalPoint(dp_h), .an(an_h), .valid(valid_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] glyph(input logic [3:0] v, input bit hex);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return hex ? 7'h08 : 7'h7F;
            4'hB: return hex ? 7'h03 : 7'h7F;
            4'hC: return hex ? 7'h46 : 7'h7F;
            4'hD: return hex ? 7'h21 : 7'h7F;
            4'hE: return hex ? 7'h06 : 7'h7F;
            default: return hex ? 7'h0E : 7'h7F;
        endcase
    endfunction

    // Expected {an, seg, dp} after edge m, given the load edge n of a scan started from BLANK
    function automatic logic [11:0] expect_out(input int m, input int n, input logic [15:0] d,
                                               input logic [3:0] dpm, input logic [3:0] bl,
                                               input logic be, input bit hex);
        int j;
        int k;
        logic off;
        logic [3:0] a;
        logic [3:0] one;
        logic [6:0] s;
        logic p;
        j = m - 2 - n;
        a = 4'hF;
        s = 7'h7F;
        p = 1'b0;
        if (j >= 0 && (j % 5) != 4) begin
            k   = (j / 5) % 4;
            one = 4'b0001 << k;
            a   = ~one;
            off = bl[k] || (be && (((m - 1 - n) & 4) != 0));
            if (!off) begin
                s = glyph(d[k*4 +: 4], hex);
                p = dpm[k];
            end
        end
        return {a, s, p};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        digits_in = dig;
        dp_in     = dpv;
        blank_in  = blv;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        n_load    = cyc;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic scan_check(input string tag, input int cycles, input bit with_hex);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check(tag, {20'h0, an, seg, decimalPoint},
                  {20'h0, expect_out(cyc, n_load, dig, dpv, blv, blink_en, 1'b0)});
            check({tag, "_valid"}, {31'h0, valid}, 32'h1);
            if (with_hex)
                check({tag, "_hex"}, {20'h0, an_h, seg_h, dp_h},
                      {20'h0, expect_out(cyc, n_load, dig, dpv, blv, blink_en, 1'b1)});
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b1;
        clear = 1'b0;
        load = 1'b0;
        digits_in = '0;
        dp_in = '0;
        blank_in = '0;
        blink_en = 1'b0;
        dig = '0;
        dpv = '0;
        blv = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Idle after reset with nothing loaded
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle", {19'h0, seg, an, decimalPoint, valid}, {19'h0, 7'h7F, 4'hF, 1'b0, 1'b0});
        end
        check("idle_hex", {19'h0, seg_h, an_h, dp_h, valid_h}, {19'h0, 7'h7F, 4'hF, 1'b0, 1'b0});

        // Normal scan of 4321 with DP on digit 0
        dig = 16'h4321;
        dpv = 4'b0001;
        blv = 4'b0000;
        do_load();
        check("load_valid", {31'h0, valid}, 32'h1);
        scan_check("scan4321", 45, 1'b1);

        // Value A on digit 0: blank in decimal mode, 'A' in hex mode
        do_clear();
        dig = 16'h432A;
        dpv = 4'b0000;
        do_load();
        tick();
        check("hexA_pre", {28'h0, an}, 32'hF);
        tick();
        check("hexA_an", {28'h0, an}, 32'hE);
        check("hexA_dec", {25'h0, seg}, 32'h7F);
        check("hexA_hex", {25'h0, seg_h}, 32'h08);
        scan_check("scan432A", 22, 1'b1);

        // Clear and load together mid-scan: clear wins
        tick();
        tick();
        dig = 16'h8765;
        digits_in = dig;
        clear = 1'b1;
        load = 1'b1;
        tick();
        clear = 1'b0;
        load = 1'b0;
        check("clr_valid", {31'h0, valid}, 32'h0);
        tick();
        check("clr_an", {28'h0, an}, 32'hF);
        check("clr_seg", {25'h0, seg}, 32'h7F);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_hold", {20'h0, an, seg, valid}, {20'h0, 4'hF, 7'h7F, 1'b0});
        end
        do_load();
        tick();
        check("restart_pre", {28'h0, an}, 32'hF);
        tick();
        check("restart_an", {28'h0, an}, 32'hE);
        check("restart_seg", {25'h0, seg}, 32'h12);
        scan_check("scan8765", 20, 1'b0);

        // Blink with digit 2 masked
        do_clear();
        blink_en = 1'b1;
        dig = 16'h4321;
        dpv = 4'b0001;
        blv = 4'b0100;
        do_load();
        scan_check("blink", 45, 1'b0);

        // Asynchronous reset asserted between edges while a digit is on
        blink_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (an != 4'hF) found = 1'b1;
        end
        check("find_on", {31'h0, found}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out", {19'h0, seg, an, decimalPoint, valid}, {19'h0, 7'h7F, 4'hF, 1'b0, 1'b0});
        check("arst_hex", {19'h0, seg_h, an_h, dp_h, valid_h}, {19'h0, 7'h7F, 4'hF, 1'b0, 1'b0});
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst", {19'h0, seg, an, decimalPoint, valid}, {19'h0, 7'h7F, 4'hF, 1'b0, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
